reg_scoreboard: RTL and testbench

Hazard-tracking scoreboard between the decode/issue stage and the 32x32 register file. It marks a destination register busy when an instruction that writes it issues. It clears the mark when the writeback stage asserts the register-file write for that register. Its combinational `issue_ready` stalls any instruction that reads a pending register (RAW) or targets one (WAW). It is the reader-side counterpart of the register file's write port, and guarantees every register-file read returns committed data.

---
 rtl/reg_scoreboard.sv | 83 ++++++++
 tb/tb_reg_scoreboard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Register-file hazard scoreboard; stalls RAW/WAW on pending writes.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int MAX_PEND = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs,
    input  logic [4:0]       issue_rt,
    input  logic             issue_use_rs,
    input  logic             issue_use_rt,
    input  logic             issue_wr,
    input  logic [4:0]       issue_dst,
    output logic             issue_ready,
    input  logic             wb_en,
    input  logic [4:0]       wb_reg,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] pend_count,
    output logic             err
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_PEND);

    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic w_dst_nz, w_full, w_acc, w_set, w_clr, w_spur;

    assign w_dst_nz = (issue_dst != 5'd0);
    assign w_full   = (cnt_q == C_MAX);

    // Ready deliberately ignores wb_*: no same-cycle bypass from writeback.
    assign issue_ready = ~((issue_use_rs & busy_q[issue_rs]) |
                           (issue_use_rt & busy_q[issue_rt]) |
                           (issue_wr & busy_q[issue_dst])    |
                           (issue_wr & w_dst_nz & w_full));

    assign w_acc  = issue_valid & issue_ready;
    assign w_set  = w_acc & issue_wr & w_dst_nz;
    assign w_clr  = wb_en & (wb_reg != 5'd0) &  busy_q[wb_reg];
    assign w_spur = wb_en & (wb_reg != 5'd0) & ~busy_q[wb_reg];

    always_comb begin
        busy_d = busy_q;
        if (w_clr) busy_d[wb_reg] = 1'b0;
        if (w_set) busy_d[issue_dst] = 1'b1;
        busy_d[0] = 1'b0;

        cnt_d = cnt_q;
        case ({w_set, w_clr})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q | w_spur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 32'd0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy       = busy_q;
    assign pend_count = cnt_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Brief    : Directed self-checking bench for reg_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rs = 5'd0;
    logic [4:0]  issue_rt = 5'd0;
    logic        issue_use_rs = 1'b0;
    logic        issue_use_rt = 1'b0;
    logic        issue_wr = 1'b0;
    logic [4:0]  issue_dst = 5'd0;
    logic        issue_ready;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_reg = 5'd0;
    logic [31:0] busy;
    logic [3:0]  pend_count;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    reg_scoreboard #(.MAX_PEND(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_use_rs (issue_use_rs),
        .issue_use_rt (issue_use_rt),
        .issue_wr     (issue_wr),
        .issue_dst    (issue_dst),
        .issue_ready  (issue_ready),
        .wb_en        (wb_en),
        .wb_reg       (wb_reg),
        .busy         (busy),
        .pend_count   (pend_count),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic wr, input logic [4:0] dst,
                       input logic urs, input logic [4:0] rs,
                       input logic urt, input logic [4:0] rt,
                       input logic wen, input logic [4:0] wreg);
        issue_valid  = v;
        issue_wr     = wr;
        issue_dst    = dst;
        issue_use_rs = urs;
        issue_rs     = rs;
        issue_use_rt = urt;
        issue_rt     = rt;
        wb_en        = wen;
        wb_reg       = wreg;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_popcount", 32'(pend_count), 32'($countones(busy)));
            chk("inv_r0", 32'(busy[0]), 32'd0);
        end
    end

    initial begin
        // Reset with arbitrary issue inputs presented
        drv(1, 1, 5'd5, 1, 5'd3, 1, 5'd9, 1, 5'd12);
        #2;
        chk("rst_busy", busy, 32'd0);
        chk("rst_cnt", 32'(pend_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdy", 32'(issue_ready), 32'd1);
        step; step;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // RAW: producer r5, readers via rs and rt, wb in the last stalled cycle
        drv(1, 1, 5'd5, 0, 0, 0, 0, 0, 0); #1 chk("raw_prod_rdy", 32'(issue_ready), 32'd1);
        step;
        chk("raw_busy_set", busy, 32'h0000_0020);
        chk("raw_cnt1", 32'(pend_count), 32'd1);
        drv(1, 0, 0, 1, 5'd5, 0, 0, 0, 0); #1 chk("raw_rs_stall", 32'(issue_ready), 32'd0);
        step;
        drv(1, 0, 0, 0, 5'd5, 1, 5'd5, 0, 0); #1 chk("raw_rt_stall", 32'(issue_ready), 32'd0);
        step;
        drv(1, 0, 0, 1, 5'd5, 0, 0, 1, 5'd5); #1 chk("raw_nobypass", 32'(issue_ready), 32'd0);
        chk("raw_busy_hold", busy, 32'h0000_0020);
        step;
        chk("raw_busy_clr", busy, 32'd0);
        chk("raw_cnt0", 32'(pend_count), 32'd0);
        drv(1, 0, 0, 1, 5'd5, 0, 0, 0, 0); #1 chk("raw_release", 32'(issue_ready), 32'd1);
        step;

        // WAW on r7
        drv(1, 1, 5'd7, 0, 0, 0, 0, 0, 0); step;
        drv(1, 1, 5'd7, 0, 0, 0, 0, 0, 0); #1 chk("waw_stall", 32'(issue_ready), 32'd0);
        step;
        drv(1, 1, 5'd7, 0, 0, 0, 0, 1, 5'd7); #1 chk("waw_stall_wb", 32'(issue_ready), 32'd0);
        step;
        chk("waw_cleared", busy, 32'd0);
        drv(1, 1, 5'd7, 0, 0, 0, 0, 0, 0); #1 chk("waw_release", 32'(issue_ready), 32'd1);
        step;
        chk("waw_reset7", busy, 32'h0000_0080);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 5'd7); step;
        // r0 writes never mark or count
        drv(1, 1, 5'd0, 0, 0, 0, 0, 0, 0); #1 chk("r0_rdy", 32'(issue_ready), 32'd1);
        step;
        chk("r0_busy", busy, 32'd0);
        chk("r0_cnt", 32'(pend_count), 32'd0);

        // Fill to MAX_PEND
        for (int i = 1; i <= 8; i++) begin
            drv(1, 1, 5'(i), 0, 0, 0, 0, 0, 0); step;
        end
        chk("full_cnt", 32'(pend_count), 32'd8);
        chk("full_busy", busy, 32'h0000_01FE);
        drv(1, 1, 5'd9, 0, 0, 0, 0, 0, 0); #1 chk("full_wr_stall", 32'(issue_ready), 32'd0);
        drv(1, 0, 0, 1, 5'd20, 0, 0, 0, 0); #1 chk("full_reader_ok", 32'(issue_ready), 32'd1);
        drv(1, 1, 5'd0, 1, 5'd20, 0, 0, 0, 0); #1 chk("full_r0_ok", 32'(issue_ready), 32'd1);
        step;
        drv(1, 1, 5'd9, 0, 0, 0, 0, 1, 5'd3); #1 chk("full_wb_nobyp", 32'(issue_ready), 32'd0);
        step;
        chk("full_after_wb", 32'(pend_count), 32'd7);
        drv(1, 1, 5'd9, 0, 0, 0, 0, 0, 0); #1 chk("full_r9_rdy", 32'(issue_ready), 32'd1);
        step;
        chk("full_cnt_back", 32'(pend_count), 32'd8);
        chk("full_busy9", busy, 32'h0000_03F6);

        // Simultaneous set and clear on different registers
        drv(0, 0, 0, 0, 0, 0, 0, 1, 5'd1); step;
        chk("sim_pre_cnt", 32'(pend_count), 32'd7);
        drv(1, 1, 5'd10, 0, 0, 0, 0, 1, 5'd2); #1 chk("sim_rdy", 32'(issue_ready), 32'd1);
        step;
        chk("sim_busy", busy, 32'h0000_07F0);
        chk("sim_cnt", 32'(pend_count), 32'd7);

        // Spurious writeback handling
        drv(0, 0, 0, 0, 0, 0, 0, 1, 5'd0); step;
        chk("wb0_noerr", 32'(err), 32'd0);
        chk("wb0_busy", busy, 32'h0000_07F0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 5'd12); step;
        chk("spur_err", 32'(err), 32'd1);
        chk("spur_busy", busy, 32'h0000_07F0);
        chk("spur_cnt", 32'(pend_count), 32'd7);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step; step;
        chk("err_sticky", 32'(err), 32'd1);

        // Asynchronous reset mid-cycle discards everything
        drv(1, 1, 5'd5, 1, 5'd6, 1, 5'd7, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 32'd0);
        chk("arst_cnt", 32'(pend_count), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_rdy", 32'(issue_ready), 32'd1);
        step;
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step;
        chk("post_rst_busy", busy, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
